// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter through a tx_start/tx_ready/tx_done_tick
// handshake, so producers can enqueue at any rate without tracking line timing.
module uart_tx_feeder #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            wr_data,
   input  logic                  wr_en,
   input  logic                  ovf_clr,
   input  logic                  tx_ready,
   input  logic                  tx_done_tick,
   output logic                  tx_start,
   output logic [7:0]            tx_data,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  busy,
   output logic                  overflow
);
   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
   localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

   typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

   state_t                state_q, state_d;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic [7:0]            tx_data_q, tx_data_d;
   logic                  ovf_q, ovf_d;
   logic [7:0]            mem_q [DEPTH];
   logic                  pop, wr_acc, drop;

   assign full     = (count_q == CNT_FULL);
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign tx_start = (state_q == START);
   assign busy     = (state_q != IDLE);
   assign tx_data  = tx_data_q;
   assign overflow = ovf_q;

   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      tx_data_d = tx_data_q;

      pop    = (state_q == IDLE) && !empty && tx_ready;
      // A pop frees the head slot this cycle, so a write into a full FIFO still fits.
      wr_acc = wr_en && (!full || pop);
      drop   = wr_en && full && !pop;

      case (state_q)
         IDLE:    if (pop) state_d = START;
         START:   state_d = BUSY;
         BUSY:    if (tx_done_tick) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (pop) begin
         tx_data_d = mem_q[rd_ptr_q];
         rd_ptr_d  = rd_ptr_q + PTR_ONE;
      end
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;

      case ({wr_acc, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      // Set has priority over clear.
      if (drop)         ovf_d = 1'b1;
      else if (ovf_clr) ovf_d = 1'b0;
      else              ovf_d = ovf_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         tx_data_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         tx_data_q <= tx_data_d;
         ovf_q     <= ovf_d;
      end
   end

   // Storage needs no reset: pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder with a simple transmitter model that
// answers each tx_start with tx_done_tick a fixed delay later.
module tb_uart_tx_feeder;
   localparam int DL2  = 4;
   localparam int DLY  = 10;

   logic           clk = 0;
   logic           reset = 0;
   logic [7:0]     wr_data = '0;
   logic           wr_en = 0;
   logic           ovf_clr = 0;
   logic           tx_ready;
   logic           tx_done_tick;
   logic           tx_start;
   logic [7:0]     tx_data;
   logic           full, empty, busy, overflow;
   logic [DL2:0]   count;

   // transmitter model state
   logic           rdy_en = 0;
   logic           tx_busy = 0;
   logic           done_m = 0;
   logic           done_f = 0;
   int             tmr = 0;
   int             since_done = -1;
   logic [7:0]     sb[$];

   int n_chk = 0;
   int n_err = 0;

   assign tx_ready     = rdy_en && !tx_busy;
   assign tx_done_tick = done_m || done_f;

   uart_tx_feeder #(.DEPTH_LOG2(DL2)) dut (
      .clk(clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en), .ovf_clr(ovf_clr),
      .tx_ready(tx_ready), .tx_done_tick(tx_done_tick), .tx_start(tx_start),
      .tx_data(tx_data), .full(full), .empty(empty), .count(count), .busy(busy),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic chk_rst_vals(input string pfx);
      chk({pfx, "_tx_start"}, tx_start, 0);
      chk({pfx, "_tx_data"}, tx_data, 8'h00);
      chk({pfx, "_busy"}, busy, 0);
      chk({pfx, "_overflow"}, overflow, 0);
      chk({pfx, "_full"}, full, 0);
      chk({pfx, "_empty"}, empty, 1);
      chk({pfx, "_count"}, count, 0);
   endtask

   // Transmitter model: checks each started byte against the scoreboard and
   // the 2-cycle done-to-start gap when bytes were pending at done time.
   always @(negedge clk) begin
      done_m = 0;
      if (!reset) begin
         tx_busy    = 0;
         tmr        = 0;
         since_done = -1;
      end else begin
         if (since_done >= 0) since_done++;
         if (tx_start) begin
            if (sb.size() == 0) chk("unexp_start", 1, 0);
            else chk("tx_data_order", tx_data, sb.pop_front());
            if (since_done >= 0) chk("done_to_start", since_done, 2);
            since_done = -1;
            tx_busy    = 1;
            tmr        = DLY;
         end else if (tx_busy) begin
            tmr--;
            if (tmr == 0) begin
               done_m     = 1;
               tx_busy    = 0;
               since_done = (sb.size() > 0) ? 0 : -1;
            end
         end
      end
   end

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((sb.size() != 0 || tx_busy || busy) && n < 3000) begin
         cyc();
         n++;
      end
      chk({tag, "_drain_timeout"}, (n >= 3000), 0);
   endtask

   initial begin
      int nstart;
      int n;
      logic [7:0] b;

      repeat (3) cyc();
      reset = 1;
      cyc();
      chk_rst_vals("rst");

      // single byte latency
      rdy_en  = 1;
      wr_data = 8'h55;
      wr_en   = 1;
      sb.push_back(8'h55);
      cyc();
      wr_en = 0;
      chk("lat_c1_start", tx_start, 0);
      chk("lat_c1_count", count, 1);
      cyc();
      chk("lat_c2_start", tx_start, 1);
      chk("lat_c2_data", tx_data, 8'h55);
      chk("lat_c2_empty", empty, 1);
      for (int i = 0; i < DLY; i++) begin
         cyc();
         chk("busy_hold", busy, 1);
         chk("start_once", tx_start, 0);
      end
      cyc();
      chk("busy_release", busy, 0);
      chk("empty_after", empty, 1);

      // five back-to-back bytes
      for (int i = 1; i <= 5; i++) begin
         wr_data = 8'(i);
         wr_en   = 1;
         sb.push_back(8'(i));
         cyc();
      end
      wr_en = 0;
      wait_drain("five");

      // fill with tx_ready low, then overflow
      rdy_en = 0;
      for (int i = 0; i < 16; i++) begin
         wr_data = 8'h10 + 8'(i);
         wr_en   = 1;
         sb.push_back(8'h10 + 8'(i));
         cyc();
      end
      chk("fill_full", full, 1);
      chk("fill_count", count, 16);
      chk("fill_no_ovf", overflow, 0);
      wr_data = 8'h99;
      cyc();
      chk("ovf_set", overflow, 1);
      chk("ovf_count", count, 16);
      ovf_clr = 1;
      cyc();
      chk("ovf_set_wins", overflow, 1);
      wr_en = 0;
      cyc();
      ovf_clr = 0;
      chk("ovf_cleared", overflow, 0);

      // pop and write in the same cycle while full, then wrap around
      rdy_en  = 1;
      wr_data = 8'h20;
      wr_en   = 1;
      sb.push_back(8'h20);
      cyc();
      wr_en = 0;
      chk("popwr_count", count, 16);
      chk("popwr_full", full, 1);
      chk("popwr_no_ovf", overflow, 0);
      b = 8'h21;
      n = 0;
      while (b <= 8'h2F && n < 3000) begin
         if (!full) begin
            wr_data = b;
            wr_en   = 1;
            sb.push_back(b);
            b++;
         end else wr_en = 0;
         cyc();
         n++;
      end
      wr_en = 0;
      chk("wrap_fill_timeout", (n >= 3000), 0);
      wait_drain("wrap");
      chk("wrap_no_ovf", overflow, 0);
      chk("wrap_empty", empty, 1);

      // reset while BUSY with 5 queued
      for (int i = 0; i < 6; i++) begin
         wr_data = 8'h60 + 8'(i);
         wr_en   = 1;
         sb.push_back(8'h60 + 8'(i));
         cyc();
      end
      wr_en = 0;
      cyc();
      chk("pre_rst_count", count, 5);
      chk("pre_rst_busy", busy, 1);
      #2 reset = 0;
      #1 chk_rst_vals("async_rst");
      sb.delete();
      repeat (3) cyc();
      chk_rst_vals("held_rst");
      reset = 1;
      nstart = 0;
      for (int i = 0; i < 30; i++) begin
         cyc();
         if (tx_start) nstart++;
      end
      chk("post_rst_starts", nstart, 0);
      chk("post_rst_busy", busy, 0);

      // done tick while IDLE and empty
      done_f = 1;
      cyc();
      done_f = 0;
      chk("stray_done_busy", busy, 0);
      chk("stray_done_start", tx_start, 0);
      cyc();
      chk("stray_done_start2", tx_start, 0);
      chk("stray_done_empty", empty, 1);
      chk("stray_done_count", count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
